// File: rtl/stats_pkg.sv
// Shared definitions for the statistics readout path: frame constants,
// UART transmitter states and counter-to-byte packing helpers.
package stats_pkg;

    localparam int unsigned STATS_CNT_W     = 11;
    localparam logic [7:0]  STATS_FRAME_HDR = 8'hA5;
    localparam int unsigned STATS_FRAME_LEN = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } stats_tx_state_t;

    function automatic logic [7:0] stats_hi(input logic [STATS_CNT_W-1:0] v);
        return {5'b0, v[10:8]};
    endfunction

    function automatic logic [7:0] stats_lo(input logic [STATS_CNT_W-1:0] v);
        return v[7:0];
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser with integrated baud counter. ready is also high in the
// last cycle of the stop bit so a following byte can start with no idle gap.
module uart_tx_byte
    import stats_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       byte_done,
    output logic       tx
);

    localparam int unsigned         BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]   BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    stats_tx_state_t   state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shr_q, shr_d;
    logic              baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shr_q   <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shr_q   <= shr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shr_d   = shr_q;
        if (state_q != IDLE) begin
            baud_d = baud_last ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = START;
                    baud_d  = '0;
                    shr_d   = data;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    shr_d = shr_q >> 1;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    if (load) begin
                        state_d = START;
                        shr_d   = data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state_q == IDLE) || ((state_q == STOP) && baud_last);
        byte_done = (state_q == STOP) && baud_last;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shr_q[0];
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/stats_uart_reporter.sv
// Snapshots the instruction statistics counters on request and sends them
// as a fixed 10-byte checksummed frame over a UART TX line.
module stats_uart_reporter
    import stats_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned CNT_W        = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] i,
    input  logic [CNT_W-1:0] r,
    input  logic [CNT_W-1:0] j,
    input  logic [CNT_W-1:0] cnt_clk,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] LAST_IDX = 4'(STATS_FRAME_LEN - 1);

    logic [CNT_W-1:0] i_q, i_d, r_q, r_d, j_q, j_d, c_q, c_d;
    logic [3:0]       byte_idx_q, byte_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic       tx_ready, tx_byte_done, tx_load;
    logic [7:0] tx_data, csum;
    logic [3:0] idx_nxt;
    logic       accept, last_byte, next_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_q        <= '0;
            r_q        <= '0;
            j_q        <= '0;
            c_q        <= '0;
            byte_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            i_q        <= i_d;
            r_q        <= r_d;
            j_q        <= j_d;
            c_q        <= c_d;
            byte_idx_q <= byte_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        accept    = start && !busy_q && tx_ready;
        last_byte = busy_q && tx_byte_done && (byte_idx_q == LAST_IDX);
        next_byte = busy_q && tx_byte_done && (byte_idx_q != LAST_IDX);
        tx_load   = accept || next_byte;
        idx_nxt   = accept ? '0 : byte_idx_q + 4'd1;

        // Byte 0 is the constant header, so the mux never needs the snapshot
        // in the same cycle it is captured.
        csum = stats_hi(i_q) ^ stats_lo(i_q) ^ stats_hi(r_q) ^ stats_lo(r_q)
             ^ stats_hi(j_q) ^ stats_lo(j_q) ^ stats_hi(c_q) ^ stats_lo(c_q);
        case (idx_nxt)
            4'd0:    tx_data = STATS_FRAME_HDR;
            4'd1:    tx_data = stats_hi(i_q);
            4'd2:    tx_data = stats_lo(i_q);
            4'd3:    tx_data = stats_hi(r_q);
            4'd4:    tx_data = stats_lo(r_q);
            4'd5:    tx_data = stats_hi(j_q);
            4'd6:    tx_data = stats_lo(j_q);
            4'd7:    tx_data = stats_hi(c_q);
            4'd8:    tx_data = stats_lo(c_q);
            4'd9:    tx_data = csum;
            default: tx_data = '0;
        endcase

        i_d        = accept ? i       : i_q;
        r_d        = accept ? r       : r_q;
        j_d        = accept ? j       : j_q;
        c_d        = accept ? cnt_clk : c_q;
        byte_idx_d = tx_load ? idx_nxt : byte_idx_q;
        busy_d     = accept ? 1'b1 : (last_byte ? 1'b0 : busy_q);
        done_d     = last_byte;
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk      (clk),
        .rst_n    (reset),
        .load     (tx_load),
        .data     (tx_data),
        .ready    (tx_ready),
        .byte_done(tx_byte_done),
        .tx       (tx)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_stats_uart_reporter.sv
// Scoreboard bench for stats_uart_reporter: a cycle model predicts busy/done
// and queues expected frame bytes; a UART decoder pops and compares them.
module tb_stats_uart_reporter;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 100 * CPB;

    logic        clk, rst_n, start;
    logic [10:0] i, r, j, cnt_clk;
    logic        tx, busy, done;

    stats_uart_reporter #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (11)
    ) dut (
        .clk    (clk),
        .reset  (rst_n),
        .start  (start),
        .i      (i),
        .r      (r),
        .j      (j),
        .cnt_clk(cnt_clk),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] fbyte(input int k, input logic [10:0] a, input logic [10:0] b,
                                         input logic [10:0] c, input logic [10:0] d);
        logic [7:0] x;
        case (k)
            0: return 8'hA5;
            1: return {5'b0, a[10:8]};
            2: return a[7:0];
            3: return {5'b0, b[10:8]};
            4: return b[7:0];
            5: return {5'b0, c[10:8]};
            6: return c[7:0];
            7: return {5'b0, d[10:8]};
            8: return d[7:0];
            default: begin
                x = 8'h00;
                for (int m = 1; m <= 8; m++) x ^= fbyte(m, a, b, c, d);
                return x;
            end
        endcase
    endfunction

    // Inputs as seen by the DUT at the most recent rising edge.
    logic        start_s, rst_s;
    logic [10:0] i_s, r_s, j_s, c_s;
    always @(posedge clk) begin
        start_s <= start;
        rst_s   <= rst_n;
        i_s     <= i;
        r_s     <= r;
        j_s     <= j;
        c_s     <= cnt_clk;
    end

    logic       m_busy = 1'b0;
    logic       exp_done = 1'b0;
    int         m_cnt = 0;
    logic [7:0] exp_q[$];
    logic       dec_active = 1'b0;
    int         dec_cnt = 0;
    logic [7:0] dec_byte = 8'h00;
    logic [7:0] e;
    logic       end_req = 1'b0;
    logic       tmo = 1'b0;

    always @(negedge clk) begin
        exp_done = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            exp_q.delete();
            dec_active = 1'b0;
        end else if (rst_s) begin
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == FRAME_CYC) begin
                    m_busy   = 1'b0;
                    exp_done = 1'b1;
                end
            end else if (start_s) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                for (int k = 0; k < 10; k++) exp_q.push_back(fbyte(k, i_s, r_s, j_s, c_s));
            end
        end

        check_val("busy", busy, m_busy);
        check_val("done", done, exp_done);
        if (!m_busy) check_val("tx_idle", tx, 1);

        if (rst_n) begin
            if (dec_active) begin
                dec_cnt++;
                if (dec_cnt == CPB / 2) begin
                    check_val("start_bit", tx, 0);
                end else if (dec_cnt >= CPB + CPB / 2 && dec_cnt < 9 * CPB
                             && (dec_cnt - CPB / 2) % CPB == 0) begin
                    dec_byte[(dec_cnt - CPB / 2) / CPB - 1] = tx;
                end else if (dec_cnt == 9 * CPB + CPB / 2) begin
                    check_val("stop_bit", tx, 1);
                    dec_active = 1'b0;
                    if (exp_q.size() == 0) begin
                        check_val("spurious_byte", {24'b0, dec_byte}, 32'h100);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("frame_byte", dec_byte, e);
                    end
                end
            end else if (tx == 1'b0) begin
                dec_active = 1'b1;
                dec_cnt    = 0;
            end
        end

        if (end_req) begin
            check_val("drain_timeout", tmo, 0);
            check_val("queue_empty", exp_q.size(), 0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        tick();
        while (m_busy && n < lim) begin
            tick();
            n++;
        end
        if (m_busy) tmo = 1'b1;
        repeat (3) tick();
    endtask

    task automatic set_vals(input logic [10:0] a, input logic [10:0] b,
                            input logic [10:0] c, input logic [10:0] d);
        i = a; r = b; j = c; cnt_clk = d;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        set_vals(0, 0, 0, 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (50) tick();

        set_vals(11'd3, 11'd3, 11'd2, 11'h123);
        pulse_start();
        wait_idle(FRAME_CYC + 100);

        set_vals(11'h155, 11'h2AA, 11'h0F0, 11'h70F);
        pulse_start();
        set_vals(11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom));
        wait_idle(FRAME_CYC + 100);

        set_vals(11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF);
        pulse_start();
        wait_idle(FRAME_CYC + 100);

        set_vals(11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom));
        pulse_start();
        repeat (100) tick();
        set_vals(11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom));
        pulse_start();
        repeat (150) tick();
        pulse_start();
        wait_idle(FRAME_CYC + 100);
        repeat (20) tick();

        start = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            set_vals(11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom));
            tick();
        end
        start = 1'b0;
        wait_idle(FRAME_CYC + 100);

        set_vals(11'h456, 11'h012, 11'h3FF, 11'h600);
        pulse_start();
        repeat (174) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        set_vals(11'h321, 11'h654, 11'h007, 11'h100);
        pulse_start();
        wait_idle(FRAME_CYC + 100);

        end_req = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end within time limit");
        $fatal(1);
    end

endmodule
